// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control FSM: FETCH, DECODE, EXEC, MEM, WB.
// Optional performance counters (cycle_cnt, instr_cnt) are built when MC_CTRL_PERF_EN is defined.
module mc_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ack,
   output logic       PC_we,
   output logic       IR_we,
   output logic       GRF_we,
   output logic       DM_we,
   output logic       mem_req,
   output logic [1:0] NPCsel,
   output logic [1:0] GRF_A3sel,
   output logic [1:0] GRF_WDsel,
   output logic       ALU_Bsel,
   output logic [2:0] ALUop,
   output logic       EXTop,
   output logic [2:0] state
`ifdef MC_CTRL_PERF_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instr_cnt
`endif
);

   localparam int unsigned CNT_W = 32;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   typedef enum logic [3:0] {
      C_OTHER, C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_JAL, C_JR
   } cls_t;

   state_t state_q, state_d;
   cls_t   cls_q, dec_cls;

   // Instruction class from the raw IR fields; only sampled in DECODE.
   always_comb begin
      dec_cls = C_OTHER;
      case (opcode)
         6'h00: begin
            case (funct)
               6'h21:   dec_cls = C_ADDU;
               6'h23:   dec_cls = C_SUBU;
               6'h08:   dec_cls = C_JR;
               default: dec_cls = C_OTHER;
            endcase
         end
         6'h0d:   dec_cls = C_ORI;
         6'h0f:   dec_cls = C_LUI;
         6'h23:   dec_cls = C_LW;
         6'h2b:   dec_cls = C_SW;
         6'h04:   dec_cls = C_BEQ;
         6'h03:   dec_cls = C_JAL;
         default: dec_cls = C_OTHER;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            if (dec_cls == C_JAL)        state_d = S_WB;
            else if (dec_cls == C_OTHER) state_d = S_FETCH;
            else                         state_d = S_EXEC;
         end
         S_EXEC: begin
            case (cls_q)
               C_ADDU, C_SUBU, C_ORI, C_LUI: state_d = S_WB;
               C_LW, C_SW:                   state_d = S_MEM;
               default:                      state_d = S_FETCH;
            endcase
         end
         S_MEM: begin
            if (mem_ack) state_d = (cls_q == C_LW) ? S_WB : S_FETCH;
         end
         S_WB:    state_d = S_FETCH;
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_FETCH;
         cls_q   <= C_OTHER;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) cls_q <= dec_cls;
      end
   end

   // Control decode from current state and latched class; everything held low during reset.
   always_comb begin
      PC_we     = 1'b0;
      IR_we     = 1'b0;
      GRF_we    = 1'b0;
      DM_we     = 1'b0;
      mem_req   = 1'b0;
      NPCsel    = 2'b00;
      GRF_A3sel = 2'b00;
      GRF_WDsel = 2'b00;
      ALU_Bsel  = 1'b0;
      ALUop     = 3'b000;
      EXTop     = 1'b0;
      if (reset) begin
         case (state_q)
            S_FETCH: begin
               IR_we = 1'b1;
               PC_we = 1'b1;
            end
            S_EXEC: begin
               case (cls_q)
                  C_SUBU: ALUop = 3'b001;
                  C_ORI: begin
                     ALU_Bsel = 1'b1;
                     ALUop    = 3'b010;
                  end
                  C_LUI: begin
                     ALU_Bsel = 1'b1;
                     ALUop    = 3'b011;
                  end
                  C_LW, C_SW: begin
                     ALU_Bsel = 1'b1;
                     EXTop    = 1'b1;
                  end
                  C_BEQ: begin
                     ALUop = 3'b001;
                     if (zero) begin
                        PC_we  = 1'b1;
                        NPCsel = 2'b01;
                     end
                  end
                  C_JR: begin
                     PC_we  = 1'b1;
                     NPCsel = 2'b11;
                  end
                  default: ALUop = 3'b000;
               endcase
            end
            S_MEM: begin
               mem_req = 1'b1;
               DM_we   = (cls_q == C_SW);
            end
            S_WB: begin
               GRF_we = 1'b1;
               case (cls_q)
                  C_ADDU, C_SUBU: begin
                     GRF_A3sel = 2'b01;
                     GRF_WDsel = 2'b01;
                  end
                  C_ORI, C_LUI: GRF_WDsel = 2'b01;
                  C_JAL: begin
                     GRF_A3sel = 2'b10;
                     GRF_WDsel = 2'b10;
                     PC_we     = 1'b1;
                     NPCsel    = 2'b10;
                  end
                  default: GRF_WDsel = 2'b00;
               endcase
            end
            default: IR_we = 1'b0;
         endcase
      end
   end

   assign state = state_q;

`ifdef MC_CTRL_PERF_EN
   // Free-running counters; instr_cnt counts every return to FETCH.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (state_d == S_FETCH && state_q != S_FETCH) instr_cnt <= instr_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle expected outputs are queued with stimulus and checked in order.
module tb_mc_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] opcode = 6'h00;
   logic [5:0] funct = 6'h00;
   logic       zero = 1'b0;
   logic       mem_ack = 1'b0;
   logic       PC_we, IR_we, GRF_we, DM_we, mem_req, ALU_Bsel, EXTop;
   logic [1:0] NPCsel, GRF_A3sel, GRF_WDsel;
   logic [2:0] ALUop, state;
`ifdef MC_CTRL_PERF_EN
   logic [31:0] cycle_cnt, instr_cnt;
`endif

   typedef struct packed {
      logic [2:0] st;
      logic       pc_we, ir_we, grf_we, dm_we, mem_req;
      logic [1:0] npc, a3, wd;
      logic       bsel;
      logic [2:0] alu;
      logic       ext;
   } out_t;

   typedef struct packed {
      logic rst;
      logic zero;
      logic ack;
      out_t exp;
   } cyc_t;

   cyc_t sb[$];
   int   checks = 0;
   int   failures = 0;

   mc_ctrl dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ack(mem_ack),
      .PC_we(PC_we), .IR_we(IR_we), .GRF_we(GRF_we), .DM_we(DM_we), .mem_req(mem_req),
      .NPCsel(NPCsel), .GRF_A3sel(GRF_A3sel), .GRF_WDsel(GRF_WDsel), .ALU_Bsel(ALU_Bsel),
      .ALUop(ALUop), .EXTop(EXTop), .state(state)
`ifdef MC_CTRL_PERF_EN
      , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
   );

   always #5 clk = ~clk;

   // en = {PC_we, IR_we, GRF_we, DM_we, mem_req}
   function automatic out_t mk(input logic [2:0] st, input logic [4:0] en, input logic [1:0] npc,
                               input logic [1:0] a3, input logic [1:0] wd, input logic b,
                               input logic [2:0] alu, input logic ext);
      out_t o;
      o.st = st;
      {o.pc_we, o.ir_we, o.grf_we, o.dm_we, o.mem_req} = en;
      o.npc = npc; o.a3 = a3; o.wd = wd; o.bsel = b; o.alu = alu; o.ext = ext;
      return o;
   endfunction

   function automatic out_t sample();
      out_t o;
      o.st = state;
      {o.pc_we, o.ir_we, o.grf_we, o.dm_we, o.mem_req} = {PC_we, IR_we, GRF_we, DM_we, mem_req};
      o.npc = NPCsel; o.a3 = GRF_A3sel; o.wd = GRF_WDsel; o.bsel = ALU_Bsel; o.alu = ALUop; o.ext = EXTop;
      return o;
   endfunction

   function automatic void push(input logic r, input logic z, input logic a, input out_t e);
      cyc_t c;
      c.rst = r; c.zero = z; c.ack = a; c.exp = e;
      sb.push_back(c);
   endfunction

   out_t F_O, D_O, IDLE_O;

   task automatic test_reset();
      out_t o;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      o = sample();
      checks++;
      if (o !== IDLE_O) begin
         failures++;
         $display("FAIL reset_hold got=%h exp=%h", o, IDLE_O);
      end
      reset = 1'b1;
      #1;
      o = sample();
      checks++;
      if (o !== F_O) begin
         failures++;
         $display("FAIL reset_release got=%h exp=%h", o, F_O);
      end
   endtask

   task automatic test_alu(input string nm, input logic [5:0] op, input logic [5:0] fn,
                           input out_t ex, input out_t wb);
      cyc_t c;
      out_t o;
      int   k = 0;
      opcode = op; funct = fn;
      push(1, 0, 0, F_O); push(1, 0, 0, D_O); push(1, 0, 0, ex); push(1, 0, 0, wb);
      while (sb.size() != 0) begin
         c = sb.pop_front();
         reset = c.rst; zero = c.zero; mem_ack = c.ack;
         #1;
         o = sample();
         checks++;
         if (o !== c.exp) begin
            failures++;
            $display("FAIL %s cyc%0d got=%h exp=%h", nm, k, o, c.exp);
         end
         @(posedge clk); #1; k++;
      end
   endtask

   task automatic test_lw_delayed();
      cyc_t c;
      out_t o;
      int   k = 0;
      out_t m = mk(3, 5'b00001, 0, 0, 0, 0, 0, 0);
      opcode = 6'h23; funct = 6'h00;
      push(1, 0, 1, F_O); push(1, 0, 1, D_O);
      push(1, 0, 0, mk(2, 0, 0, 0, 0, 1, 3'b000, 1));
      push(1, 0, 0, m); push(1, 0, 0, m); push(1, 0, 1, m);
      push(1, 0, 0, mk(4, 5'b00100, 0, 2'b00, 2'b00, 0, 0, 0));
      while (sb.size() != 0) begin
         c = sb.pop_front();
         reset = c.rst; zero = c.zero; mem_ack = c.ack;
         #1;
         o = sample();
         checks++;
         if (o !== c.exp) begin
            failures++;
            $display("FAIL lw cyc%0d got=%h exp=%h", k, o, c.exp);
         end
         @(posedge clk); #1; k++;
      end
   endtask

   task automatic test_sw();
      cyc_t c;
      out_t o;
      int   k = 0;
      opcode = 6'h2b; funct = 6'h00;
      push(1, 0, 0, F_O); push(1, 0, 0, D_O);
      push(1, 0, 0, mk(2, 0, 0, 0, 0, 1, 3'b000, 1));
      push(1, 0, 1, mk(3, 5'b00011, 0, 0, 0, 0, 0, 0));
      while (sb.size() != 0) begin
         c = sb.pop_front();
         reset = c.rst; zero = c.zero; mem_ack = c.ack;
         #1;
         o = sample();
         checks++;
         if (o !== c.exp) begin
            failures++;
            $display("FAIL sw cyc%0d got=%h exp=%h", k, o, c.exp);
         end
         @(posedge clk); #1; k++;
      end
   endtask

   task automatic test_branch(input string nm, input logic [5:0] op, input logic [5:0] fn,
                              input logic z, input out_t ex);
      cyc_t c;
      out_t o;
      int   k = 0;
      opcode = op; funct = fn;
      push(1, z, 0, F_O); push(1, z, 0, D_O); push(1, z, 0, ex);
      while (sb.size() != 0) begin
         c = sb.pop_front();
         reset = c.rst; zero = c.zero; mem_ack = c.ack;
         #1;
         o = sample();
         checks++;
         if (o !== c.exp) begin
            failures++;
            $display("FAIL %s cyc%0d got=%h exp=%h", nm, k, o, c.exp);
         end
         @(posedge clk); #1; k++;
      end
      zero = 1'b0;
   endtask

   task automatic test_jal_nop();
      cyc_t c;
      out_t o;
      int   k = 0;
      opcode = 6'h03; funct = 6'h00;
      push(1, 0, 0, F_O); push(1, 0, 0, D_O);
      push(1, 0, 0, mk(4, 5'b10100, 2'b10, 2'b10, 2'b10, 0, 0, 0));
      push(1, 0, 0, F_O); push(1, 0, 0, D_O);
      push(1, 0, 0, F_O); push(1, 0, 0, D_O);
      while (sb.size() != 0) begin
         c = sb.pop_front();
         reset = c.rst; zero = c.zero; mem_ack = c.ack;
         #1;
         o = sample();
         checks++;
         if (o !== c.exp) begin
            failures++;
            $display("FAIL jal_nop cyc%0d got=%h exp=%h", k, o, c.exp);
         end
         @(posedge clk); #1; k++;
         // after jal's WB, run two unrecognised encodings back to back
         if (k == 3) opcode = 6'h3f;
         if (k == 5) begin opcode = 6'h00; funct = 6'h00; end
      end
   endtask

   task automatic test_reset_in_mem();
      cyc_t c;
      out_t o;
      int   k = 0;
      opcode = 6'h23; funct = 6'h00;
      push(1, 0, 0, F_O); push(1, 0, 0, D_O);
      push(1, 0, 0, mk(2, 0, 0, 0, 0, 1, 3'b000, 1));
      push(1, 0, 0, mk(3, 5'b00001, 0, 0, 0, 0, 0, 0));
      push(0, 0, 0, mk(3, 0, 0, 0, 0, 0, 0, 0));
      push(0, 0, 0, IDLE_O);
      while (sb.size() != 0) begin
         c = sb.pop_front();
         reset = c.rst; zero = c.zero; mem_ack = c.ack;
         #1;
         o = sample();
         checks++;
         if (o !== c.exp) begin
            failures++;
            $display("FAIL rst_mem cyc%0d got=%h exp=%h", k, o, c.exp);
         end
         @(posedge clk); #1; k++;
      end
`ifdef MC_CTRL_PERF_EN
      checks++;
      if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
         failures++;
         $display("FAIL rst_mem_cnt cycle=%0d instr=%0d exp=0/0", cycle_cnt, instr_cnt);
      end
`endif
      reset = 1'b1;
      #1;
      o = sample();
      checks++;
      if (o !== F_O) begin
         failures++;
         $display("FAIL rst_mem_refetch got=%h exp=%h", o, F_O);
      end
   endtask

`ifdef MC_CTRL_PERF_EN
   task automatic test_perf();
      logic [31:0] c0, i0;
      c0 = cycle_cnt; i0 = instr_cnt;
      opcode = 6'h00; funct = 6'h21;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (cycle_cnt !== c0 + 32'd4 || instr_cnt !== i0 + 32'd1) begin
         failures++;
         $display("FAIL perf_addu cycle=%0d instr=%0d exp=%0d/%0d", cycle_cnt, instr_cnt, c0 + 32'd4, i0 + 32'd1);
      end
   endtask
`endif

   initial begin
      F_O    = mk(0, 5'b11000, 0, 0, 0, 0, 0, 0);
      D_O    = mk(1, 0, 0, 0, 0, 0, 0, 0);
      IDLE_O = mk(0, 0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_alu("addu", 6'h00, 6'h21, mk(2, 0, 0, 0, 0, 0, 3'b000, 0),
               mk(4, 5'b00100, 0, 2'b01, 2'b01, 0, 0, 0));
      test_alu("subu", 6'h00, 6'h23, mk(2, 0, 0, 0, 0, 0, 3'b001, 0),
               mk(4, 5'b00100, 0, 2'b01, 2'b01, 0, 0, 0));
      test_alu("ori", 6'h0d, 6'h21, mk(2, 0, 0, 0, 0, 1, 3'b010, 0),
               mk(4, 5'b00100, 0, 2'b00, 2'b01, 0, 0, 0));
      test_alu("lui", 6'h0f, 6'h00, mk(2, 0, 0, 0, 0, 1, 3'b011, 0),
               mk(4, 5'b00100, 0, 2'b00, 2'b01, 0, 0, 0));
      test_lw_delayed();
      test_sw();
      test_branch("beq_z1", 6'h04, 6'h00, 1'b1, mk(2, 5'b10000, 2'b01, 0, 0, 0, 3'b001, 0));
      test_branch("beq_z0", 6'h04, 6'h00, 1'b0, mk(2, 0, 0, 0, 0, 0, 3'b001, 0));
      test_branch("jr", 6'h00, 6'h08, 1'b0, mk(2, 5'b10000, 2'b11, 0, 0, 0, 3'b000, 0));
      test_jal_nop();
`ifdef MC_CTRL_PERF_EN
      test_perf();
`endif
      test_reset_in_mem();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
